// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_slave (plus _pkg_riscv_defines, axi_read_if, axi_write_if)
// Brief    : Word-addressed AXI memory slave with independent read/write FSMs.
//            Optional read wait states are enabled by defining AXI_MEM_WAIT_EN.
// Revision : 1.0
// ============================================================================
package _pkg_riscv_defines;
  localparam int         ADDR_WIDTH      = 32;
  localparam int         DATA_WIDTH      = 32;
  localparam int         AXI_ARLEN_WIDTH = 8;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
endpackage

interface axi_read_if;
  import _pkg_riscv_defines::*;
  logic [ADDR_WIDTH-1:0]      araddr;
  logic [AXI_ARLEN_WIDTH-1:0] arlen;
  logic [2:0]                 arsize;
  logic [1:0]                 arburst;
  logic                       arvalid;
  logic                       arready;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       rlast;
  logic [1:0]                 rresp;
  logic                       rvalid;
  logic                       rready;
  modport slave  (input  araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rdata, rlast, rresp, rvalid);
  modport master (output araddr, arlen, arsize, arburst, arvalid, rready,
                  input  arready, rdata, rlast, rresp, rvalid);
endinterface

interface axi_write_if;
  import _pkg_riscv_defines::*;
  logic [ADDR_WIDTH-1:0]      awaddr;
  logic [AXI_ARLEN_WIDTH-1:0] awlen;
  logic [2:0]                 awsize;
  logic [1:0]                 awburst;
  logic                       awvalid;
  logic                       awready;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [DATA_WIDTH/8-1:0]    wstrb;
  logic                       wlast;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;
  modport slave  (input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
                  output awready, wready, bresp, bvalid);
  modport master (output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
                  input  awready, wready, bresp, bvalid);
endinterface

module axi_mem_slave
  import _pkg_riscv_defines::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  axi_read_if.slave  rd,
  axi_write_if.slave wr
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int LEN_W = AXI_ARLEN_WIDTH;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Upper address bits must be zero: no aliasing past the end of memory.
  function automatic logic beat_ok(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] burst);
    return (a[ADDR_WIDTH-1:IDX_W+2] == '0) && (burst != AXI_BURST_WRAP);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst);
    return (burst == AXI_BURST_FIXED) ? a : a + ADDR_WIDTH'(4);
  endfunction

  logic [1:0]            rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, ld_addr;
  logic [LEN_W-1:0]      rlen_q, rlen_d, rbeat_q, rbeat_d, ld_len, ld_beat;
  logic [1:0]            rburst_q, rburst_d, ld_burst;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d, ld_en;

`ifdef AXI_MEM_WAIT_EN
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [WCNT_W-1:0] rwait_q, rwait_d;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  // Read data is registered when a beat is loaded, so it stays stable under
  // backpressure and a same-cycle write to the word is not seen.
  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rburst_d = rburst_q;
    rbeat_d  = rbeat_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    ld_en    = 1'b0;
    ld_addr  = raddr_q;
    ld_len   = rlen_q;
    ld_burst = rburst_q;
    ld_beat  = rbeat_q;
`ifdef AXI_MEM_WAIT_EN
    rwait_d  = rwait_q;
`endif
    case (rstate_q)
      R_IDLE: begin
        if (rd.arvalid) begin
          raddr_d  = rd.araddr;
          rlen_d   = rd.arlen;
          rburst_d = rd.arburst;
          rbeat_d  = '0;
          ld_addr  = rd.araddr;
          ld_len   = rd.arlen;
          ld_burst = rd.arburst;
          ld_beat  = '0;
`ifdef AXI_MEM_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            rstate_d = R_DATA;
            ld_en    = 1'b1;
          end else begin
            rstate_d = R_WAIT;
            rwait_d  = '0;
          end
`else
          rstate_d = R_DATA;
          ld_en    = 1'b1;
`endif
        end
      end
`ifdef AXI_MEM_WAIT_EN
      R_WAIT: begin
        if (rwait_q == WCNT_W'(WAIT_CYCLES - 1)) begin
          rstate_d = R_DATA;
          ld_en    = 1'b1;
        end else begin
          rwait_d = rwait_q + WCNT_W'(1);
        end
      end
`endif
      R_DATA: begin
        if (rd.rready) begin
          if (rlast_q) begin
            rstate_d = R_IDLE;
          end else begin
            ld_addr = next_addr(raddr_q, rburst_q);
            ld_beat = rbeat_q + LEN_W'(1);
            raddr_d = ld_addr;
            rbeat_d = ld_beat;
            ld_en   = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    if (ld_en) begin
      if (beat_ok(ld_addr, ld_burst)) begin
        rdata_d = mem_q[ld_addr[IDX_W+1:2]];
        rresp_d = AXI_RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = AXI_RESP_SLVERR;
      end
      rlast_d = (ld_beat == ld_len);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rburst_q <= '0;
      rbeat_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= AXI_RESP_OKAY;
      rlast_q  <= 1'b0;
`ifdef AXI_MEM_WAIT_EN
      rwait_q  <= '0;
`endif
    end else begin
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rburst_q <= rburst_d;
      rbeat_q  <= rbeat_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
`ifdef AXI_MEM_WAIT_EN
      rwait_q  <= rwait_d;
`endif
    end
  end

  assign rd.arready = (rstate_q == R_IDLE);
  assign rd.rvalid  = (rstate_q == R_DATA);
  assign rd.rdata   = rdata_q;
  assign rd.rresp   = rresp_q;
  assign rd.rlast   = rlast_q;

  logic [1:0]            wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [LEN_W-1:0]      wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  werr_q, werr_d, mem_we;

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wburst_d = wburst_q;
    wbeat_d  = wbeat_q;
    werr_d   = werr_q;
    mem_we   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (wr.awvalid) begin
          waddr_d  = wr.awaddr;
          wlen_d   = wr.awlen;
          wburst_d = wr.awburst;
          wbeat_d  = '0;
          werr_d   = 1'b0;
          wstate_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wr.wvalid) begin
          mem_we = beat_ok(waddr_q, wburst_q);
          // awlen alone sets the burst length; a misplaced wlast only flags an error.
          if (!mem_we || (wr.wlast != (wbeat_q == wlen_q))) werr_d = 1'b1;
          if (wbeat_q == wlen_q) begin
            wstate_d = W_RESP;
          end else begin
            waddr_d = next_addr(waddr_q, wburst_q);
            wbeat_d = wbeat_q + LEN_W'(1);
          end
        end
      end
      W_RESP: begin
        if (wr.bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wburst_q <= '0;
      wbeat_q  <= '0;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wburst_q <= wburst_d;
      wbeat_q  <= wbeat_d;
      werr_q   <= werr_d;
    end
  end

  // Memory array has no reset so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wr.wstrb[i]) mem_q[waddr_q[IDX_W+1:2]][8*i +: 8] <= wr.wdata[8*i +: 8];
      end
    end
  end

  assign wr.awready = (wstate_q == W_IDLE);
  assign wr.wready  = (wstate_q == W_DATA);
  assign wr.bvalid  = (wstate_q == W_RESP);
  assign wr.bresp   = werr_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  logic unused_size;
  assign unused_size = ^{rd.arsize, wr.awsize};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_slave
// Brief    : Table-driven single-beat vectors plus burst, stall, concurrency
//            and reset sequences for axi_mem_slave.
// Revision : 1.0
// ============================================================================
module tb_axi_mem_slave;
  import _pkg_riscv_defines::*;

  localparam int MEM_WORDS   = 1024;
  localparam int WAIT_CYCLES = 2;
`ifdef AXI_MEM_WAIT_EN
  localparam int EXP_LAT = WAIT_CYCLES + 1;
`else
  localparam int EXP_LAT = 1;
`endif
  localparam int TMO = 64;
  localparam logic [1:0] OK  = AXI_RESP_OKAY;
  localparam logic [1:0] ERR = AXI_RESP_SLVERR;
  localparam logic [1:0] FX  = AXI_BURST_FIXED;
  localparam logic [1:0] INC = AXI_BURST_INCR;
  localparam logic [1:0] WRP = AXI_BURST_WRAP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_read_if  rd_if ();
  axi_write_if wr_if ();

  axi_mem_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rd    (rd_if),
    .wr    (wr_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, " arready"}, rd_if.arready, 1'b1);
    chk1({tag, " awready"}, wr_if.awready, 1'b1);
    chk1({tag, " rvalid"},  rd_if.rvalid,  1'b0);
    chk1({tag, " wready"},  wr_if.wready,  1'b0);
    chk1({tag, " bvalid"},  wr_if.bvalid,  1'b0);
    chk1({tag, " rlast"},   rd_if.rlast,   1'b0);
    chk32({tag, " rdata"},  rd_if.rdata,   32'h0);
    chk2({tag, " rresp"},   rd_if.rresp,   OK);
    chk2({tag, " bresp"},   wr_if.bresp,   OK);
  endtask

  // All tasks start and end on a falling edge.
  task automatic ar_send(input logic [31:0] a, input int len, input logic [1:0] burst, output int lat);
    int n = 0;
    rd_if.araddr  = a;
    rd_if.arlen   = AXI_ARLEN_WIDTH'(len);
    rd_if.arburst = burst;
    rd_if.arsize  = 3'd2;
    rd_if.arvalid = 1'b1;
    while (!rd_if.arready && n < TMO) begin @(negedge clk); n++; end
    chk1("arready wait", rd_if.arready, 1'b1);
    @(negedge clk);
    rd_if.arvalid = 1'b0;
    lat = 1;
    while (!rd_if.rvalid && lat < TMO) begin @(negedge clk); lat++; end
    chk1("rvalid wait", rd_if.rvalid, 1'b1);
  endtask

  task automatic rd_beats(input string tag, input int len, input logic [31:0] ed [8],
                          input logic [1:0] er [8], input bit stall);
    for (int b = 0; b <= len; b++) begin
      int n = 0;
      while (!rd_if.rvalid && n < TMO) begin @(negedge clk); n++; end
      if (!stall && b > 0) chki({tag, " back-to-back"}, n, 0);
      if (stall) begin
        rd_if.rready = 1'b0;
        chk32({tag, " rdata pre-stall"}, rd_if.rdata, ed[b]);
        @(negedge clk);
        chk1({tag, " rvalid held"}, rd_if.rvalid, 1'b1);
      end
      chk32({tag, " rdata"}, rd_if.rdata, ed[b]);
      chk2({tag, " rresp"}, rd_if.rresp, er[b]);
      chk1({tag, " rlast"}, rd_if.rlast, b == len);
      rd_if.rready = 1'b1;
      @(negedge clk);
      if (stall) rd_if.rready = 1'b0;
    end
    rd_if.rready = 1'b0;
    chk1({tag, " arready after last"}, rd_if.arready, 1'b1);
  endtask

  task automatic rd1(input logic [31:0] a, input logic [1:0] burst, output logic [31:0] d,
                     output logic [1:0] r, output logic l, output int lat);
    ar_send(a, 0, burst, lat);
    d = rd_if.rdata;
    r = rd_if.rresp;
    l = rd_if.rlast;
    rd_if.rready = 1'b1;
    @(negedge clk);
    rd_if.rready = 1'b0;
  endtask

  // early < 0: wlast on the final beat; otherwise wlast only on beat 'early'.
  task automatic wr_burst(input logic [31:0] a, input int len, input logic [1:0] burst,
                          input logic [31:0] wd [8], input logic [3:0] strb, input int early,
                          output logic [1:0] resp);
    int n = 0;
    wr_if.awaddr  = a;
    wr_if.awlen   = AXI_ARLEN_WIDTH'(len);
    wr_if.awburst = burst;
    wr_if.awsize  = 3'd2;
    wr_if.awvalid = 1'b1;
    while (!wr_if.awready && n < TMO) begin @(negedge clk); n++; end
    chk1("awready wait", wr_if.awready, 1'b1);
    @(negedge clk);
    wr_if.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      int m = 0;
      wr_if.wvalid = 1'b1;
      wr_if.wdata  = wd[b];
      wr_if.wstrb  = strb;
      wr_if.wlast  = (early >= 0) ? (b == early) : (b == len);
      while (!wr_if.wready && m < TMO) begin @(negedge clk); m++; end
      chk1("wready wait", wr_if.wready, 1'b1);
      @(negedge clk);
    end
    wr_if.wvalid = 1'b0;
    wr_if.wlast  = 1'b0;
    chk1("bvalid after last beat", wr_if.bvalid, 1'b1);
    resp = wr_if.bresp;
    wr_if.bready = 1'b1;
    @(negedge clk);
    wr_if.bready = 1'b0;
    chk1("awready after B", wr_if.awready, 1'b1);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  burst;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 18;
  vec_t        vt [NV];
  logic [31:0] wd [8];
  logic [31:0] ed [8];
  logic [1:0]  er [8];
  logic [31:0] d;
  logic [1:0]  r;
  logic        l;
  int          lat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int n;
    vt[0]  = '{1'b1, 32'h010,  32'h11223344, 4'hF, INC, 32'h0,        OK};
    vt[1]  = '{1'b0, 32'h010,  32'h0,        4'h0, INC, 32'h11223344, OK};
    vt[2]  = '{1'b1, 32'h020,  32'hAABBCCDD, 4'hF, INC, 32'h0,        OK};
    vt[3]  = '{1'b1, 32'h020,  32'h000000EE, 4'h1, INC, 32'h0,        OK};
    vt[4]  = '{1'b0, 32'h020,  32'h0,        4'h0, INC, 32'hAABBCCEE, OK};
    vt[5]  = '{1'b1, 32'h000,  32'h5A5A5A5A, 4'hF, INC, 32'h0,        OK};
    vt[6]  = '{1'b0, 32'h1000, 32'h0,        4'h0, INC, 32'h0,        ERR};
    vt[7]  = '{1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, INC, 32'h0,        ERR};
    vt[8]  = '{1'b0, 32'h000,  32'h0,        4'h0, INC, 32'h5A5A5A5A, OK};
    vt[9]  = '{1'b1, 32'h030,  32'h12345678, 4'hF, INC, 32'h0,        OK};
    vt[10] = '{1'b1, 32'h030,  32'h00000055, 4'hF, WRP, 32'h0,        ERR};
    vt[11] = '{1'b0, 32'h030,  32'h0,        4'h0, INC, 32'h12345678, OK};
    vt[12] = '{1'b0, 32'h030,  32'h0,        4'h0, WRP, 32'h0,        ERR};
    vt[13] = '{1'b1, 32'h044,  32'hFFFFFFFF, 4'hF, INC, 32'h0,        OK};
    vt[14] = '{1'b1, 32'h044,  32'h0BADF00D, 4'hA, INC, 32'h0,        OK};
    vt[15] = '{1'b0, 32'h044,  32'h0,        4'h0, INC, 32'h0BFFF0FF, OK};
    vt[16] = '{1'b1, 32'hFFC,  32'h600DCAFE, 4'hF, FX,  32'h0,        OK};
    vt[17] = '{1'b0, 32'hFFC,  32'h0,        4'h0, FX,  32'h600DCAFE, OK};

    rd_if.araddr = '0; rd_if.arlen = '0; rd_if.arsize = 3'd2; rd_if.arburst = INC;
    rd_if.arvalid = 1'b0; rd_if.rready = 1'b0;
    wr_if.awaddr = '0; wr_if.awlen = '0; wr_if.awsize = 3'd2; wr_if.awburst = INC;
    wr_if.awvalid = 1'b0; wr_if.wdata = '0; wr_if.wstrb = '0; wr_if.wlast = 1'b0;
    wr_if.wvalid = 1'b0; wr_if.bready = 1'b0;
    wd = '{default: 32'h0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vt[i].is_wr) begin
        wd[0] = vt[i].data;
        wr_burst(vt[i].addr, 0, vt[i].burst, wd, vt[i].strb, -1, r);
        chk2({tag, " bresp"}, r, vt[i].exp_resp);
      end else begin
        rd1(vt[i].addr, vt[i].burst, d, r, l, lat);
        chk32({tag, " rdata"}, d, vt[i].exp_data);
        chk2({tag, " rresp"}, r, vt[i].exp_resp);
        chk1({tag, " rlast"}, l, 1'b1);
        chki({tag, " latency"}, lat, EXP_LAT);
      end
    end

    // 4-beat INCR write then reads with and without backpressure
    wd = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
    wr_burst(32'h100, 3, INC, wd, 4'hF, -1, r);
    chk2("incr4 bresp", r, OK);
    ed = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
    er = '{default: OK};
    ar_send(32'h100, 3, INC, lat);
    chki("incr4 latency", lat, EXP_LAT);
    rd_beats("incr4 stall", 3, ed, er, 1'b1);
    ar_send(32'h100, 3, INC, lat);
    rd_beats("incr4 stream", 3, ed, er, 1'b0);

    // FIXED burst: every beat hits the same word
    wd = '{32'd7, 32'd8, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    wr_burst(32'h300, 2, FX, wd, 4'hF, -1, r);
    chk2("fixed bresp", r, OK);
    ed = '{32'd9, 32'd9, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    ar_send(32'h300, 2, FX, lat);
    rd_beats("fixed read", 2, ed, er, 1'b0);

    // INCR bursts running past the end of memory
    wd = '{32'hA1, 32'hA2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    wr_burst(32'hFF8, 1, INC, wd, 4'hF, -1, r);
    chk2("tail write bresp", r, OK);
    ed = '{32'hA1, 32'hA2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    er = '{OK, OK, ERR, ERR, OK, OK, OK, OK};
    ar_send(32'hFF8, 3, INC, lat);
    rd_beats("past-end read", 3, ed, er, 1'b0);
    er = '{default: OK};
    wd = '{32'hB1, 32'hB2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    wr_burst(32'hFFC, 1, INC, wd, 4'hF, -1, r);
    chk2("past-end write bresp", r, ERR);
    rd1(32'hFFC, INC, d, r, l, lat);
    chk32("past-end write in-range beat", d, 32'hB1);
    rd1(32'h000, INC, d, r, l, lat);
    chk32("past-end write no alias", d, 32'h5A5A5A5A);

    // wlast early on beat 0, then wlast never asserted
    wd = '{32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'd0, 32'd0, 32'd0, 32'd0};
    wr_burst(32'h200, 1, INC, wd, 4'hF, 0, r);
    chk2("early wlast bresp", r, ERR);
    wd = '{32'hC3, 32'hC4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    wr_burst(32'h208, 1, INC, wd, 4'hF, 5, r);
    chk2("missing wlast bresp", r, ERR);
    ed = '{32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'd0, 32'd0, 32'd0, 32'd0};
    ar_send(32'h200, 3, INC, lat);
    rd_beats("wlast-err readback", 3, ed, er, 1'b0);

    // Same-cycle write data beat and read address handshake to one word
    wd[0] = 32'hCAFEF00D;
    wr_burst(32'h500, 0, INC, wd, 4'hF, -1, r);
    wr_if.awaddr = 32'h500; wr_if.awlen = '0; wr_if.awburst = INC; wr_if.awvalid = 1'b1;
    chk1("conc awready", wr_if.awready, 1'b1);
    @(negedge clk);
    wr_if.awvalid = 1'b0;
    wr_if.wvalid = 1'b1; wr_if.wdata = 32'h01020304; wr_if.wstrb = 4'hF; wr_if.wlast = 1'b1;
    rd_if.araddr = 32'h500; rd_if.arlen = '0; rd_if.arburst = INC; rd_if.arvalid = 1'b1;
    chk1("conc wready", wr_if.wready, 1'b1);
    chk1("conc arready", rd_if.arready, 1'b1);
    @(negedge clk);
    wr_if.wvalid = 1'b0; wr_if.wlast = 1'b0; rd_if.arvalid = 1'b0;
    chk1("conc bvalid", wr_if.bvalid, 1'b1);
    n = 0;
    while (!rd_if.rvalid && n < TMO) begin @(negedge clk); n++; end
    chk1("conc rvalid", rd_if.rvalid, 1'b1);
    chk32("conc read data", rd_if.rdata, (EXP_LAT == 1) ? 32'hCAFEF00D : 32'h01020304);
    rd_if.rready = 1'b1; wr_if.bready = 1'b1;
    @(negedge clk);
    rd_if.rready = 1'b0; wr_if.bready = 1'b0;
    rd1(32'h500, INC, d, r, l, lat);
    chk32("conc write landed", d, 32'h01020304);

    // Reset during beat 2 of a 4-beat read
    ar_send(32'h100, 3, INC, lat);
    rd_if.rready = 1'b1;
    @(negedge clk);
    rd_if.rready = 1'b0;
    chk32("mid-read beat2 data", rd_if.rdata, 32'd2);
    rst_n = 1'b0;
    #1;
    chk_reset("mid-read reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post-reset rvalid", rd_if.rvalid, 1'b0);
    chk1("post-reset arready", rd_if.arready, 1'b1);
    ed = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0};
    ar_send(32'h100, 3, INC, lat);
    rd_beats("post-reset read", 3, ed, er, 1'b0);

    // Reset during a write burst: beats already written remain
    wd = '{default: 32'h0};
    wr_burst(32'h600, 2, INC, wd, 4'hF, -1, r);
    wr_if.awaddr = 32'h600; wr_if.awlen = 8'd3; wr_if.awburst = INC; wr_if.awvalid = 1'b1;
    chk1("mid-write awready", wr_if.awready, 1'b1);
    @(negedge clk);
    wr_if.awvalid = 1'b0;
    wr_if.wvalid = 1'b1; wr_if.wstrb = 4'hF; wr_if.wlast = 1'b0; wr_if.wdata = 32'hD0;
    chk1("mid-write wready b0", wr_if.wready, 1'b1);
    @(negedge clk);
    wr_if.wdata = 32'hD1;
    chk1("mid-write wready b1", wr_if.wready, 1'b1);
    @(negedge clk);
    wr_if.wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset("mid-write reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ed = '{32'hD0, 32'hD1, 32'h0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    ar_send(32'h600, 2, INC, lat);
    rd_beats("mid-write readback", 2, ed, er, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
- REQ-001 SHALL have parameter MEM_WORDS, default 1024: memory depth in 32-bit words (power of two).
- REQ-002 SHALL have parameter WAIT_CYCLES, default 2: read wait states; used only when AXI_MEM_WAIT_EN is defined.
- REQ-003 SHALL take ADDR_WIDTH, DATA_WIDTH (32) and AXI_ARLEN_WIDTH from _pkg_riscv_defines.
- REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on the rising edge.
- REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port rd, axi_read_if.slave: read address channel (araddr, arlen, arsize, arburst, arvalid, arready) and read data channel (rdata, rlast, rresp, rvalid, rready).
- REQ-007 SHALL have port wr, axi_write_if.slave: write address, write data and write response channels.

Function
- REQ-008 SHALL index words as addr[ADDR_WIDTH-1:2]; size fields are ignored and every beat is 4 bytes.
- REQ-009 SHALL run independent read and write FSMs; neither stalls the other.
- REQ-010 Read FSM SHALL use states R_IDLE, R_WAIT and R_DATA; arready=1 only in R_IDLE.
- REQ-011 On an arvalid&&arready handshake, SHALL latch addr, len and burst, clear the beat counter, and go to R_DATA (R_WAIT if the wait feature is enabled).
- REQ-012 In R_DATA, SHALL hold rvalid=1 with rdata = mem[current word] and rlast=1 iff beat==len.
- REQ-013 SHALL hold rdata, rresp and rlast stable while rvalid&&!rready.
- REQ-014 On rvalid&&rready, SHALL advance the beat: INCR adds 1 word; FIXED keeps the address. On the last beat it SHALL return to R_IDLE, with arready=1 in the next cycle.
- REQ-015 Without wait states, SHALL assert rvalid in the cycle after the AR handshake, and SHALL sustain 1 beat/cycle when rready=1.
- REQ-016 Write FSM SHALL use states W_IDLE, W_DATA and W_RESP; awready=1 only in W_IDLE, and wready=1 only in W_DATA.
- REQ-017 On each wvalid&&wready beat, SHALL write the byte lanes where wstrb[i]=1 to the current word and advance the address as in REQ-014.
- REQ-018 SHALL end a write burst after exactly awlen+1 beats, then go to W_RESP with bvalid=1 held until bready.
- REQ-019 On bvalid&&bready, SHALL return to W_IDLE.
- REQ-020 rresp SHALL be SLVERR for any beat whose word index is >= MEM_WORDS, or whose burst is WRAP; such a beat returns rdata=0. All other beats SHALL return OKAY.
- REQ-021 A write beat outside memory, or in a WRAP burst, SHALL NOT modify memory and SHALL force bresp=SLVERR.
- REQ-022 bresp SHALL be SLVERR if wlast differs from (beat==awlen) on any beat; the burst length is still set by awlen.
- REQ-023 A write and a read beat to the same word in the same cycle SHALL return the old data to the read.
- REQ-024 An INCR burst that runs past MEM_WORDS SHALL NOT wrap; beats beyond the end get SLVERR.

Reset
- REQ-025 While rst_n=0, SHALL force R_IDLE and W_IDLE, with arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rdata=0, rresp=OKAY and bresp=OKAY.
- REQ-026 Reset mid-burst SHALL abort the burst without a response; memory contents SHALL NOT be cleared; beats already written remain.

Configuration
- REQ-027 When AXI_MEM_WAIT_EN is defined, SHALL spend exactly WAIT_CYCLES cycles in R_WAIT after each AR handshake, with rvalid=0, before R_DATA.
- REQ-028 When AXI_MEM_WAIT_EN is undefined, R_WAIT and its counter SHALL NOT exist, and the AR handshake goes straight to R_DATA.

Verification
- REQ-029 Write 0x11223344 to 0x10 (len 0, wstrb 0xF), then read 0x10: expect bresp OKAY, rdata 0x11223344, rlast=1, rresp OKAY.
- REQ-030 INCR write of 4 beats at 0x100 (1, 2, 3, 4), then INCR read of 4 beats with rready toggled every other cycle: expect 1, 2, 3, 4 in order, data stable while stalled, and rlast only on beat 4.
- REQ-031 Write 0xAABBCCDD, then write 0x000000EE with wstrb 0x1 at the same address, then read: expect 0xAABBCCEE.
- REQ-032 Read at word MEM_WORDS (0x1000 with default depth) and write with wlast early on beat 0 of a len-1 burst: expect rresp SLVERR with rdata 0, and bresp SLVERR after 2 beats.
- REQ-033 With AXI_MEM_WAIT_EN and WAIT_CYCLES=2: expect rvalid first high 3 cycles after the AR handshake.
- REQ-034 Assert rst_n low during beat 2 of a 4-beat read, then release: expect rvalid=0 and arready=1, and a new read then succeeds.
